// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding for the input debouncer
package debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STABLE  = 2'd0,
    PENDING = 2'd1
  } state_t;

endpackage

// File: rtl/input_synchronizer.sv
// rtl/input_synchronizer.sv - multi-flop synchroniser for an asynchronous level
module input_synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise and debounce a bouncy input; edge pulses under DEBOUNCE_EDGE_EN
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 1000,
  parameter int   CNT_W         = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic d_clean,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt
    $error("input_debouncer: STABLE_CYCLES must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               ONE_SHOT = (STABLE_CYCLES == 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             accept;

  input_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (din_raw),
    .dout (s)
  );

  // With a one-cycle window the very first differing sample is accepted from STABLE.
  always_comb begin
    accept = 1'b0;
    if (s != d_clean) begin
      if (state == STABLE)
        accept = ONE_SHOT;
      else
        accept = (cnt == LAST_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= STABLE;
      cnt     <= '0;
      d_clean <= RESET_LEVEL;
    end else begin
      case (state)
        STABLE: begin
          if (s != d_clean) begin
            if (accept) begin
              d_clean <= s;
              cnt     <= '0;
            end else begin
              state <= PENDING;
              cnt   <= CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        PENDING: begin
          if (s == d_clean) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (accept) begin
            d_clean <= s;
            cnt     <= '0;
            state   <= STABLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & s;
      fall <= accept & ~s;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - table, directed and random checks of input_debouncer
module tb_input_debouncer;

  localparam int SC = 4;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din_raw = 1'b0;
  logic d_clean, rise, fall;

  int checks = 0;
  int errors = 0;

  input_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (SC),
    .CNT_W         (16),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din_raw (din_raw),
    .d_clean (d_clean),
    .rise    (rise),
    .fall    (fall)
  );

  always #20 clk = ~clk;

  // Reference: input seen by the filter is din delayed by two edges; the output
  // flips once the last SC observed samples all disagree with it.
  bit sync_m[2];
  bit obs[$];
  bit dc_m, rise_m, fall_m;

  task automatic model_reset();
    sync_m[0] = 1'b0;
    sync_m[1] = 1'b0;
    obs.delete();
    dc_m   = 1'b0;
    rise_m = 1'b0;
    fall_m = 1'b0;
  endtask

  task automatic model_edge(input bit d);
    bit seen;
    bit all_diff;
    seen = sync_m[1];
    sync_m[1] = sync_m[0];
    sync_m[0] = d;
    obs.push_back(seen);
    if (obs.size() > SC) void'(obs.pop_front());
    rise_m = 1'b0;
    fall_m = 1'b0;
    all_diff = (obs.size() == SC);
    foreach (obs[i]) if (obs[i] == dc_m) all_diff = 1'b0;
    if (all_diff) begin
      dc_m   = ~dc_m;
      rise_m = dc_m;
      fall_m = ~dc_m;
      obs.delete();
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".d_clean"}, d_clean, dc_m);
    chk({tag, ".rise"}, rise, EDGE_EN & rise_m);
    chk({tag, ".fall"}, fall, EDGE_EN & fall_m);
    if (rise === 1'b1 && fall === 1'b1) chk({tag, ".both_pulses"}, 1'b1, 1'b0);
  endtask

  // Drive one cycle: input set on the falling edge, outputs checked on the next falling edge.
  task automatic step(input bit d, input string tag);
    din_raw = d;
    @(posedge clk);
    model_edge(d);
    @(negedge clk);
    chk_model(tag);
  endtask

  typedef struct {
    bit din;
    bit dc;
    bit r;
    bit f;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int edges;
    bit seen_high;

    for (int i = 0; i < 14; i++) begin
      tbl[i].din = (i < 7);
      tbl[i].dc  = (i < 7) ? (i >= 5) : (i < 12);
      tbl[i].r   = (i == 5);
      tbl[i].f   = (i == 12);
    end

    // 1: reset held with din high
    model_reset();
    rst = 1'b0;
    din_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset.d_clean", d_clean, 1'b0);
      chk("reset.rise", rise, 1'b0);
      chk("reset.fall", fall, 1'b0);
    end
    din_raw = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, "idle");

    // 2 and 5: clean rise then clean fall from the table
    for (int i = 0; i < 14; i++) begin
      din_raw = tbl[i].din;
      @(posedge clk);
      model_edge(tbl[i].din);
      @(negedge clk);
      chk($sformatf("tbl[%0d].d_clean", i), d_clean, tbl[i].dc);
      chk($sformatf("tbl[%0d].rise", i), rise, EDGE_EN & tbl[i].r);
      chk($sformatf("tbl[%0d].fall", i), fall, EDGE_EN & tbl[i].f);
    end

    // 3: bounce restarts the count
    for (int i = 0; i < 3; i++) step(1'b1, "bounce.pre");
    step(1'b0, "bounce.glitch");
    edges = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, "bounce.hold");
      if (d_clean === 1'b1 && edges == 0) edges = i + 1;
    end
    chk("bounce.latency_is_6", (edges == 6), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, "bounce.back");

    // 4: short pulse never reaches the output
    seen_high = 1'b0;
    step(1'b1, "short");
    step(1'b1, "short");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, "short.tail");
      if (d_clean !== 1'b0) seen_high = 1'b1;
    end
    chk("short.no_change", seen_high, 1'b0);

    // 6: reset in the middle of a pending count
    for (int i = 0; i < 4; i++) step(1'b1, "midrst.pre");
    #5 rst = 1'b0;
    model_reset();
    #1;
    chk("midrst.d_clean", d_clean, 1'b0);
    chk("midrst.rise", rise, 1'b0);
    @(negedge clk);
    chk_model("midrst.held");
    rst = 1'b1;
    edges = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, "midrst.hold");
      if (d_clean === 1'b1 && edges == 0) edges = i + 1;
    end
    chk("midrst.latency_is_6", (edges == 6), 1'b1);

    // random runs of 1..7 cycles each
    for (int k = 0; k < 80; k++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) step(lvl, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
